acs_cmp_scheduler: RTL
======================

// Module: acs_cmp_scheduler
// PURPOSE
//  Add-compare-select sequencer for the Viterbi path-metric unit. Time-shares one
//  external 6-bit signed less-than comparator (a<b via a+~b+1 and Ovf^s[5]) across all trellis states.
//  It then reuses the same comparator to find the minimum new metric and normalises all metrics by it.
//  Sits between the branch-metric unit (bm_in) and the survivor-path memory (dec_out).
// PARAMETERS
//  NUM_STATES  4  trellis states, power of 2, >=2; M = log2(NUM_STATES)
//  PM_W        6  path-metric width; must equal comparator width
//  BM_W        2  branch-metric width, unsigned, BM_W < PM_W
// PORTS
//  clk       in   1                   clock, all state on rising edge
//  rst_n     in   1                   reset, asynchronous, active-low
//  start     in   1                   begin one trellis step; sampled only in IDLE
//  pm_in     in   NUM_STATES*PM_W     old metrics; state s at [s*PM_W +: PM_W]
//  bm_in     in   2*NUM_STATES*BM_W   branch metric for (state s, pred j) at [(2s+j)*BM_W +: BM_W]
//  cmp_a     out  PM_W                comparator operand a (combinational from regs)
//  cmp_b     out  PM_W                comparator operand b
//  cmp_alb   in   1                   comparator result, 1 when a<b signed, same cycle
//  busy      out  1                   high in any state other than IDLE
//  done      out  1                   one-cycle pulse: pm_out/dec_out updated
//  pm_out    out  NUM_STATES*PM_W     normalised new metrics, held until next done
//  dec_out   out  NUM_STATES          decision bit per state (1 = pred1 survived)
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE; busy=0, done=0, pm_out=0, dec_out=0, all
//    internal regs 0, cmp_a/cmp_b=0. Reset mid-step aborts the step, no done.
//  - Trellis: next state s = {u, old[M-1:1]}; preds of s: p0={s[M-2:0],1'b0},
//    p1={s[M-2:0],1'b1} (for M=1: p0=0, p1=1).
//  - Metrics are non-negative; add saturates: cand = min(pm+bm, 2^(PM_W-1)-1), keeping
//    operands positive for the signed comparator.
//  - FSM: IDLE -> ACS -> MIN -> NORM -> IDLE.
//    IDLE: on start=1 capture pm_in, bm_in; idx=0; go ACS. start ignored elsewhere.
//    ACS (NUM_STATES cycles, idx=0..N-1): cmp_a=cand1(idx), cmp_b=cand0(idx);
//      new_pm[idx] = cmp_alb ? cand1 : cand0; dec[idx]=cmp_alb (tie -> pred0, dec 0).
//      Last idx: min_reg=new_pm[0], idx=1, go MIN.
//    MIN (NUM_STATES-1 cycles, idx=1..N-1): cmp_a=new_pm[idx], cmp_b=min_reg;
//      if cmp_alb min_reg=new_pm[idx]. After idx=N-1 go NORM.
//    NORM (1 cycle): pm_out[s]=new_pm[s]-min_reg (never negative); dec_out=dec;
//      done=1 for this edge only; go IDLE.
//  - Outside ACS/MIN, cmp_a=cmp_b=0.
//  - Latency: start accepted at edge E0 -> done high in cycle after edge E0+2*NUM_STATES
//    (8 cycles for N=4). Throughput: one step per 2*NUM_STATES+1 cycles (start may be
//    re-asserted in the IDLE cycle after done).
//  - pm_out/dec_out change only on the done edge; inputs may change after capture.
//  - No combinational path from start to any output; cmp_alb->regs only.
// TESTING  (N=4, PM_W=6, BM_W=2; comparator model = 6-bit signed a<b)
//  1 Hold rst_n=0, toggle start -> busy=0, done=0, pm_out=0, dec_out=0; cmp_a=cmp_b=0.
//  2 pm_in={s3..s0}={1,4,2,5}, bm all 1, start -> 8 cycles later done=1,
//    pm_out={s3..s0}={0,1,0,1}, dec_out=4'b1111.
//  3 pm_in all 7, bm all 2 (ties) -> pm_out all 0, dec_out=4'b0000.
//  4 pm_in={31,31,31,31}, bm all 3 -> saturate 31, normalise -> pm_out all 0,
//    dec 0; pm_in s0=31,s1=0, rest 0, bm 0 -> s0,s2 pick pred1: dec_out=4'b0101.
//  5 start pulsed during ACS and MIN -> ignored, exactly one done; back-to-back start
//    in IDLE after done -> second done 8 cycles later with new results.
//  6 rst_n low during MIN -> immediate IDLE, outputs 0, no done; next start completes.

Source files
------------

// File: rtl/acs_cmp_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : acs_cmp_scheduler_if
//  Description : Bus bundle for the ACS sequencer.
//                start/pm_in/bm_in : one trellis step request plus old metrics
//                                    and branch metrics
//                cmp_a/cmp_b/cmp_alb : shared external signed comparator
//                busy/done/pm_out/dec_out : status, normalised metrics,
//                                    survivor decisions
//                The slave modport is the sequencer. The master modport is
//                its environment, which also supplies the comparator result.
//  Revision    : 1.0  initial release
// ============================================================================
interface acs_cmp_scheduler_if #(
    parameter int NUM_STATES = 4,
    parameter int PM_W       = 6,
    parameter int BM_W       = 2
);
    logic                         start;
    logic [NUM_STATES*PM_W-1:0]   pm_in;
    logic [2*NUM_STATES*BM_W-1:0] bm_in;
    logic [PM_W-1:0]              cmp_a;
    logic [PM_W-1:0]              cmp_b;
    logic                         cmp_alb;
    logic                         busy;
    logic                         done;
    logic [NUM_STATES*PM_W-1:0]   pm_out;
    logic [NUM_STATES-1:0]        dec_out;

    modport master (
        output start, pm_in, bm_in, cmp_alb,
        input  cmp_a, cmp_b, busy, done, pm_out, dec_out
    );

    modport slave (
        input  start, pm_in, bm_in, cmp_alb,
        output cmp_a, cmp_b, busy, done, pm_out, dec_out
    );
endinterface
`default_nettype wire

// File: rtl/acs_cmp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : acs_cmp_scheduler
//  Description : Add-compare-select sequencer for the Viterbi path-metric
//                unit. One shared signed comparator is used for two jobs.
//                First it runs the ACS for each trellis state, one state per
//                cycle. Then it searches for the minimum new metric, and
//                every metric is normalised by that minimum.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - acs_cmp_scheduler_if.slave. It carries start,
//                         pm_in and bm_in; the comparator operands and
//                         result; and busy, done, pm_out and dec_out.
//  Revision    : 1.0  initial release
// ============================================================================
module acs_cmp_scheduler #(
    parameter int NUM_STATES = 4,
    parameter int PM_W       = 6,
    parameter int BM_W       = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    acs_cmp_scheduler_if.slave bus
);
    localparam int              c_IDX_W  = $clog2(NUM_STATES);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_STATES - 1);
    localparam logic [c_IDX_W-1:0] c_ONE  = c_IDX_W'(1);
    // Largest positive value. Saturating here keeps operands positive for the signed comparator.
    localparam logic [PM_W-1:0] c_PM_MAX = {1'b0, {(PM_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACS  = 2'd1,
        S_MIN  = 2'd2,
        S_NORM = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [PM_W-1:0]       r_pm_old [NUM_STATES];
    logic [BM_W-1:0]       r_bm     [2*NUM_STATES];
    logic [PM_W-1:0]       r_new_pm [NUM_STATES];
    logic [NUM_STATES-1:0] r_dec;
    logic [PM_W-1:0]       r_min;
    logic [PM_W-1:0]       r_pm_out [NUM_STATES];
    logic [NUM_STATES-1:0] r_dec_out;
    logic                  r_done;

    logic [c_IDX_W-1:0]    w_p0;
    logic [c_IDX_W-1:0]    w_p1;
    logic [PM_W-1:0]       w_cand0;
    logic [PM_W-1:0]       w_cand1;
    logic [PM_W-1:0]       w_cmp_a;
    logic [PM_W-1:0]       w_cmp_b;

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                                 input logic [BM_W-1:0] bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + {{(PM_W+1-BM_W){1'b0}}, bm};
        return (sum > {1'b0, c_PM_MAX}) ? c_PM_MAX : sum[PM_W-1:0];
    endfunction

    // Predecessors of state s are {s[M-2:0],0} and {s[M-2:0],1}. The shift drops the top bit of idx.
    assign w_p0    = r_idx << 1;
    assign w_p1    = w_p0 | c_ONE;
    assign w_cand0 = sat_add(r_pm_old[w_p0], r_bm[{r_idx, 1'b0}]);
    assign w_cand1 = sat_add(r_pm_old[w_p1], r_bm[{r_idx, 1'b1}]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmp_a     = '0;
        w_cmp_b     = '0;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_ACS;
            S_ACS: begin
                w_cmp_a = w_cand1;
                w_cmp_b = w_cand0;
                if (r_idx == c_LAST) w_state_nxt = S_MIN;
            end
            S_MIN: begin
                w_cmp_a = r_new_pm[r_idx];
                w_cmp_b = r_min;
                if (r_idx == c_LAST) w_state_nxt = S_NORM;
            end
            S_NORM:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_dec     <= '0;
            r_min     <= '0;
            r_dec_out <= '0;
            r_done    <= 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                r_pm_old[i] <= '0;
                r_new_pm[i] <= '0;
                r_pm_out[i] <= '0;
            end
            for (int i = 0; i < 2*NUM_STATES; i++) r_bm[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_idx <= '0;
                    for (int i = 0; i < NUM_STATES; i++)
                        r_pm_old[i] <= bus.pm_in[i*PM_W +: PM_W];
                    for (int i = 0; i < 2*NUM_STATES; i++)
                        r_bm[i] <= bus.bm_in[i*BM_W +: BM_W];
                end
                S_ACS: begin
                    // A tie keeps pred0 because cand1 must be strictly smaller.
                    r_new_pm[r_idx] <= bus.cmp_alb ? w_cand1 : w_cand0;
                    r_dec[r_idx]    <= bus.cmp_alb;
                    if (r_idx == c_LAST) begin
                        r_min <= r_new_pm[0];
                        r_idx <= c_ONE;
                    end else begin
                        r_idx <= r_idx + c_ONE;
                    end
                end
                S_MIN: begin
                    if (bus.cmp_alb) r_min <= r_new_pm[r_idx];
                    r_idx <= r_idx + c_ONE;
                end
                S_NORM: begin
                    for (int i = 0; i < NUM_STATES; i++)
                        r_pm_out[i] <= r_new_pm[i] - r_min;
                    r_dec_out <= r_dec;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar s = 0; s < NUM_STATES; s++) begin : g_pack_pm
            assign bus.pm_out[s*PM_W +: PM_W] = r_pm_out[s];
        end
    endgenerate

    assign bus.cmp_a   = w_cmp_a;
    assign bus.cmp_b   = w_cmp_b;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.dec_out = r_dec_out;
endmodule
`default_nettype wire
